// File: rtl/cache_refill.sv
// Block-refill engine for the direct-mapped data cache. It fetches a
// 2**BLOCK_SIZE-word block critical word first, wraps around the block, and forwards the critical word early.
module cache_refill #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3,
    localparam int JUST_DATA    = DATA_WIDTH * (2 ** BLOCK_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    output logic                     mem_rd_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_rvalid,
    output logic                     crit_valid,
    output logic [DATA_WIDTH-1:0]    crit_data,
    output logic                     blk_valid,
    output logic [JUST_DATA-1:0]     blk_data,
    output logic [ADDRESS_WIDTH-1:0] blk_address,
    output logic                     busy
);

    localparam int WORDS = 2 ** BLOCK_SIZE;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               state;
    logic [ADDRESS_WIDTH-1:0] base;
    logic [BLOCK_SIZE-1:0]    start;
    logic [BLOCK_SIZE:0]      beat;
    logic [BLOCK_SIZE-1:0]    offset;
    logic                     last_beat;

    // Offset arithmetic is BLOCK_SIZE bits wide, so it wraps within the block.
    assign offset    = start + beat[BLOCK_SIZE-1:0];
    assign last_beat = (beat == (BLOCK_SIZE+1)'(WORDS - 1));

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign mem_rd_en   = (state == ISSUE);
    assign blk_valid   = (state == DONE);
    assign blk_address = base;

    always_comb begin
        mem_addr = '0;
        if (state == ISSUE) begin
            mem_addr = {base[ADDRESS_WIDTH-1:BLOCK_SIZE], offset};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            start      <= '0;
            beat       <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            blk_data   <= '0;
        end else begin
            crit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base  <= {req_address[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
                        start <= req_address[BLOCK_SIZE-1:0];
                        beat  <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (mem_rvalid) begin
                        for (int unsigned k = 0; k < WORDS; k++) begin
                            if (offset == BLOCK_SIZE'(k)) begin
                                blk_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                            end
                        end
                        if (beat == '0) begin
                            crit_valid <= 1'b1;
                            crit_data  <= mem_rdata;
                        end
                        if (last_beat) begin
                            state <= DONE;
                        end else begin
                            beat  <= beat + 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: a memory model returns 0x1000+addr and the
// bench checks fetch order, critical-word forwarding, block assembly, timing and reset abort.
module tb_cache_refill;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [29:0]  req_address;
    logic         mem_rd_en;
    logic [29:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_rvalid;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         blk_valid;
    logic [255:0] blk_data;
    logic [29:0]  blk_address;
    logic         busy;

    cache_refill #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (30),
        .BLOCK_SIZE    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_address (req_address),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .crit_valid  (crit_valid),
        .crit_data   (crit_data),
        .blk_valid   (blk_valid),
        .blk_data    (blk_data),
        .blk_address (blk_address),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int          cyc = 0;
    logic [29:0] strobes[$];
    int          countdown = -1;
    logic [29:0] pend_addr = '0;
    int          outstanding_viol = 0;
    int          max_extra = 0;
    bit          spur_req = 1'b0;

    int           acc_cyc = 0;
    int           crit_cnt = 0;
    int           blk_cnt = 0;
    int           crit_rel = 0;
    int           blk_rel = 0;
    int           overlap = 0;
    logic [31:0]  crit_val = '0;
    logic [255:0] blk_val = '0;
    logic [29:0]  blk_addr_s = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: answers each strobe 1+extra cycles later; also injects stray rvalid pulses on request.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                countdown = -1;
                continue;
            end
            if (countdown == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h1000 + {2'b00, pend_addr};
                countdown  = -1;
            end else if (countdown > 0) begin
                countdown--;
            end
            if (spur_req) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEADBEEF;
                spur_req   = 1'b0;
            end
            if (mem_rd_en) begin
                if (countdown != -1) outstanding_viol++;
                strobes.push_back(mem_addr);
                pend_addr = mem_addr;
                countdown = int'($urandom_range(max_extra, 0));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_valid && req_ready) acc_cyc = cyc;
                if (crit_valid) begin
                    crit_cnt++;
                    crit_val = crit_data;
                    crit_rel = cyc - acc_cyc;
                end
                if (blk_valid) begin
                    blk_cnt++;
                    blk_val    = blk_data;
                    blk_addr_s = blk_address;
                    blk_rel    = cyc - acc_cyc;
                    if (crit_valid) overlap++;
                end
            end
        end
    end

    task automatic check_reset_vals(input string p);
        check({p, "_req_ready"},   req_ready,   1);
        check({p, "_busy"},        busy,        0);
        check({p, "_mem_rd_en"},   mem_rd_en,   0);
        check({p, "_mem_addr"},    mem_addr,    0);
        check({p, "_crit_valid"},  crit_valid,  0);
        check({p, "_crit_data"},   crit_data,   0);
        check({p, "_blk_valid"},   blk_valid,   0);
        check({p, "_blk_data"},    blk_data,    0);
        check({p, "_blk_address"}, blk_address, 0);
    endtask

    task automatic wait_done(input int b0, input bit timing);
        int t = 0;
        while (blk_cnt == b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("blk_timeout", blk_cnt == b0, 0);
        if (timing) check("ready_after_blk", req_ready, 1);
    endtask

    task automatic verify(input logic [29:0] addr, input int c0, input int b0, input bit timing);
        logic [29:0]  base;
        logic [2:0]   s;
        logic [255:0] eb;
        logic [29:0]  ea;
        logic [29:0]  ga;
        base = addr & ~30'h7;
        s    = addr[2:0];
        for (int k = 0; k < 8; k++) eb[k*32 +: 32] = 32'h1000 + {2'b00, base} + 32'(k);
        check($sformatf("strobe_count_%0h", addr), strobes.size(), 8);
        for (int i = 0; i < 8; i++) begin
            ea = base | 30'((int'(s) + i) & 7);
            ga = (i < strobes.size()) ? strobes[i] : 30'h3fffffff;
            check($sformatf("strobe%0d_%0h", i, addr), ga, ea);
        end
        check($sformatf("crit_count_%0h", addr), crit_cnt - c0, 1);
        check($sformatf("blk_count_%0h", addr), blk_cnt - b0, 1);
        check($sformatf("crit_data_%0h", addr), crit_val, 32'h1000 + {2'b00, addr});
        check($sformatf("blk_data_%0h", addr), blk_val, eb);
        check($sformatf("blk_address_%0h", addr), blk_addr_s, base);
        if (timing) begin
            check($sformatf("crit_cycle_%0h", addr), crit_rel, 3);
            check($sformatf("blk_cycle_%0h", addr), blk_rel, 17);
        end
    endtask

    task automatic do_refill(input logic [29:0] addr, input bit timing);
        int c0;
        int b0;
        c0 = crit_cnt;
        b0 = blk_cnt;
        strobes.delete();
        @(posedge clk);
        #2;
        req_valid   = 1'b1;
        req_address = addr;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        wait_done(b0, timing);
        verify(addr, c0, b0, timing);
    endtask

    initial begin
        int t;
        int b0;
        int c1;
        int b1;
        int bcyc;
        int bc;
        int cc;
        logic [255:0] bd;
        logic [31:0]  cd;
        logic [29:0]  ba;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_refill(30'h40, 1'b1);
        do_refill(30'h45, 1'b1);

        // Stray rvalid while idle must leave everything untouched.
        @(negedge clk);
        bd = blk_data;
        cd = crit_data;
        ba = blk_address;
        bc = blk_cnt;
        cc = crit_cnt;
        @(posedge clk);
        #2;
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_consumed", spur_req, 0);
        check("spur_blk_data", blk_data, bd);
        check("spur_crit_data", crit_data, cd);
        check("spur_blk_address", blk_address, ba);
        check("spur_busy", busy, 0);
        check("spur_blk_cnt", blk_cnt, bc);
        check("spur_crit_cnt", crit_cnt, cc);

        max_extra = 5;
        do_refill(30'h40, 1'b0);
        check("one_outstanding", outstanding_viol, 0);
        max_extra = 0;

        // Abort a refill with reset after beat 3 has been strobed.
        b0 = blk_cnt;
        strobes.delete();
        @(posedge clk);
        #2;
        req_valid   = 1'b1;
        req_address = 30'h40;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        t = 0;
        while (strobes.size() < 4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("abort_reached_beat3", strobes.size() >= 4, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_blk", blk_cnt, b0);
        check("abort_idle", req_ready, 1);
        do_refill(30'h80, 1'b1);

        // Back-to-back: req_valid stays high across two requests.
        strobes.delete();
        @(posedge clk);
        #2;
        req_valid   = 1'b1;
        req_address = 30'h40;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!blk_valid && t < 200);
        check("b2b_first_blk", blk_valid, 1);
        check("b2b_first_addr", blk_address, 30'h40);
        check("b2b_ready_in_done", req_ready, 0);
        bcyc        = cyc;
        req_address = 30'h88;
        strobes.delete();
        @(negedge clk);
        check("b2b_ready_after_blk", req_ready, 1);
        @(posedge clk);
        #2;
        b1 = blk_cnt;
        c1 = crit_cnt;
        req_valid = 1'b0;
        check("b2b_accept_cycle", acc_cyc, bcyc + 1);
        check("b2b_busy", busy, 1);
        wait_done(b1, 1'b1);
        verify(30'h88, c1, b1, 1'b1);

        check("no_crit_blk_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
